mem32_port_arbiter: RTL and testbench

- Shares the single-port mem32 instance between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write) of the pipelined MIPS core.
- Arbitrates requests, drives mem32's mem_read/mem_write/address/data_in, and times read-data return.
- Returns captured data to the winning requester with a valid pulse.
- Contains a starvation guard so IF is never locked out by back-to-back DM traffic.

---
 rtl/mem32_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem32_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem32_port_arbiter.sv
// Arbiter sharing one single-port mem32 between instruction fetch (read-only)
// and data memory (read/write), with fixed read latency and an IF starvation guard.
module mem32_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

  state_e      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_dm_q, owner_dm_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;

  logic        if_win, dm_win, misaligned;
  logic [31:0] win_addr;
  logic        if_ack_c, dm_ack_c, if_err_c, dm_err_c, mem_read_c, mem_write_c;

  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    starve_cnt_d  = starve_cnt_q;
    owner_dm_d    = owner_dm_q;
    if_rvalid_d   = 1'b0;
    dm_rvalid_d   = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    if_win        = 1'b0;
    dm_win        = 1'b0;
    misaligned    = 1'b0;
    win_addr      = '0;
    if_ack_c      = 1'b0;
    dm_ack_c      = 1'b0;
    if_err_c      = 1'b0;
    dm_err_c      = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // DM normally wins; IF is forced through once it has lost STARVE_MAX times in a row
        if_win   = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));
        dm_win   = dm_req && !if_win;
        win_addr = if_win ? if_addr : dm_addr;

        if (if_win || dm_win) begin
          mem_address_d = win_addr;
          misaligned    = (win_addr[1:0] != 2'b00);
          if_ack_c      = if_win;
          dm_ack_c      = dm_win;
          if_err_c      = if_win && misaligned;
          dm_err_c      = dm_win && misaligned;
          if (!misaligned) begin
            if (dm_win && dm_we) begin
              mem_write_c   = 1'b1;
              mem_data_in_d = dm_wdata;
            end else begin
              mem_read_c = 1'b1;
              owner_dm_d = dm_win;
              lat_cnt_d  = LAT_INIT;
              state_d    = S_WAIT;
            end
          end
        end

        if (!if_req || if_win) begin
          starve_cnt_d = '0;
        end else if (dm_win && (starve_cnt_q < STARVE_LIM)) begin
          starve_cnt_d = starve_cnt_q + 8'd1;
        end
      end

      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          state_d = S_IDLE;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_data_out;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_data_out;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lat_cnt_q     <= '0;
      starve_cnt_q  <= '0;
      owner_dm_q    <= 1'b0;
      if_rvalid_q   <= 1'b0;
      dm_rvalid_q   <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      starve_cnt_q  <= starve_cnt_d;
      owner_dm_q    <= owner_dm_d;
      if_rvalid_q   <= if_rvalid_d;
      dm_rvalid_q   <= dm_rvalid_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  // Issue-cycle outputs are combinational, so they are forced low while reset is held
  assign if_ack      = rst_n & if_ack_c;
  assign dm_ack      = rst_n & dm_ack_c;
  assign if_err      = rst_n & if_err_c;
  assign dm_err      = rst_n & dm_err_c;
  assign mem_read    = rst_n & mem_read_c;
  assign mem_write   = rst_n & mem_write_c;
  assign mem_address = rst_n ? mem_address_d : '0;
  assign mem_data_in = rst_n ? mem_data_in_d : '0;
  assign if_rvalid   = if_rvalid_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_mem32_port_arbiter.sv
// Self-checking bench for mem32_port_arbiter: directed vector table, contention,
// reset-during-wait and a randomized phase checked against a transaction-level model.
module tb_mem32_port_arbiter;

  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 3;

  localparam logic [7:0] F_IFACK = 8'b1000_0000;
  localparam logic [7:0] F_DMACK = 8'b0100_0000;
  localparam logic [7:0] F_IFERR = 8'b0010_0000;
  localparam logic [7:0] F_DMERR = 8'b0001_0000;
  localparam logic [7:0] F_RD    = 8'b0000_1000;
  localparam logic [7:0] F_WR    = 8'b0000_0100;
  localparam logic [7:0] F_IFRV  = 8'b0000_0010;
  localparam logic [7:0] F_DMRV  = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, if_rvalid, if_err, dm_ack, dm_rvalid, dm_err;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem32_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 16) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0101);
  endfunction

  // Behavioural mem32: loaded with a known pattern on the first clock edge
  logic [31:0] mem_arr [0:1023];
  logic [9:0]  rd_idx;
  bit          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
      rd_idx     <= '0;
      mem_loaded <= 1'b1;
    end else begin
      if (mem_write) mem_arr[mem_address[11:2]] <= mem_data_in;
      if (mem_read)  rd_idx <= mem_address[11:2];
    end
  end
  assign mem_data_out = mem_arr[rd_idx];

  task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                               input logic d_req, input logic d_we,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata);
    @(negedge clk);
    if_req   = i_req;
    if_addr  = i_addr;
    dm_req   = d_req;
    dm_we    = d_we;
    dm_addr  = d_addr;
    dm_wdata = d_wdata;
    #2;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [7:0]  flags;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic i_req, input logic [31:0] i_addr, input logic d_req,
                         input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
                         input logic [7:0] flags, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    vec_t v;
    v.if_req = i_req;  v.if_addr = i_addr;  v.dm_req = d_req;  v.dm_we = d_we;
    v.dm_addr = d_addr; v.dm_wdata = d_wdata; v.flags = flags;
    v.exp_addr = exp_addr; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  // Reference model state for the randomized phase
  logic [31:0] ref_mem [0:1023];
  int          m_busy, m_losses, m_cyc, m_rv_at;
  logic        m_rv_dm;
  logic [31:0] m_rv_data, m_if_rdata, m_dm_rdata;
  logic        if_pend, dm_pend, r_dm_we;
  logic [31:0] r_if_addr, r_dm_addr, r_dm_wdata;
  logic        g_if, g_dm, bad, do_read, do_write, exp_if_rv, exp_dm_rv;
  logic [31:0] g_addr;
  byte         got[$];
  string       expect_order;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h800 + 32'($urandom_range(0, 15)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;

    // Reset: every output low even with both requesters asserting
    applyStimulus(1, 32'h40, 1, 1, 32'h10, 32'h1);
    checkOutput("reset if_ack", if_ack, 0);
    checkOutput("reset dm_ack", dm_ack, 0);
    checkOutput("reset mem_read", mem_read, 0);
    checkOutput("reset mem_write", mem_write, 0);
    checkOutput("reset mem_address", mem_address, 0);
    checkOutput("reset mem_data_in", mem_data_in, 0);
    checkOutput("reset if_rvalid", if_rvalid, 0);
    checkOutput("reset dm_rdata", dm_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    add_vec(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add_vec(1, 32'h40, 0, 0, 0, 0, F_IFACK | F_RD, 32'h40, 0);
    for (int k = 0; k < MEM_LAT; k++) add_vec(0, 0, 1, 1, 32'h200, 32'hCAFEF00D, 8'h00, 0, 0);
    add_vec(0, 0, 1, 1, 32'h200, 32'hCAFEF00D, F_DMACK | F_WR | F_IFRV, 32'h200, 32'hDEADBEEF);
    add_vec(0, 0, 1, 1, 32'h100, 32'h12345678, F_DMACK | F_WR, 32'h100, 0);
    add_vec(0, 0, 1, 0, 32'h100, 0, F_DMACK | F_RD, 32'h100, 0);
    for (int k = 0; k < MEM_LAT; k++) add_vec(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, F_DMRV, 0, 32'h12345678);
    add_vec(0, 0, 1, 0, 32'h102, 0, F_DMACK | F_DMERR, 0, 0);
    add_vec(1, 32'h41, 0, 0, 0, 0, F_IFACK | F_IFERR, 0, 0);
    add_vec(0, 0, 1, 0, 32'h200, 0, F_DMACK | F_RD, 32'h200, 0);
    for (int k = 0; k < MEM_LAT; k++) add_vec(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, F_DMRV, 0, 32'hCAFEF00D);

    foreach (vecs[i]) begin
      v = vecs[i];
      applyStimulus(v.if_req, v.if_addr, v.dm_req, v.dm_we, v.dm_addr, v.dm_wdata);
      checkOutput($sformatf("v%0d if_ack", i), if_ack, v.flags[7]);
      checkOutput($sformatf("v%0d dm_ack", i), dm_ack, v.flags[6]);
      checkOutput($sformatf("v%0d if_err", i), if_err, v.flags[5]);
      checkOutput($sformatf("v%0d dm_err", i), dm_err, v.flags[4]);
      checkOutput($sformatf("v%0d mem_read", i), mem_read, v.flags[3]);
      checkOutput($sformatf("v%0d mem_write", i), mem_write, v.flags[2]);
      checkOutput($sformatf("v%0d if_rvalid", i), if_rvalid, v.flags[1]);
      checkOutput($sformatf("v%0d dm_rvalid", i), dm_rvalid, v.flags[0]);
      if (v.flags[1]) checkOutput($sformatf("v%0d if_rdata", i), if_rdata, v.exp_data);
      if (v.flags[0]) checkOutput($sformatf("v%0d dm_rdata", i), dm_rdata, v.exp_data);
      if (v.flags[3] || v.flags[2]) checkOutput($sformatf("v%0d mem_address", i), mem_address, v.exp_addr);
      if (v.flags[2]) checkOutput($sformatf("v%0d mem_data_in", i), mem_data_in, v.dm_wdata);
    end

    // Contention: both requesters read continuously; IF must break through every fourth grant
    expect_order = "DDDIDDDI";
    for (int k = 0; k < 200 && got.size() < 8; k++) begin
      applyStimulus(1, 32'h0, 1, 0, 32'h4, 0);
      if (dm_ack) got.push_back("D");
      if (if_ack) got.push_back("I");
    end
    checkOutput("contention grant count", got.size(), 8);
    for (int k = 0; k < got.size() && k < 8; k++)
      checkOutput($sformatf("contention grant %0d", k), got[k], expect_order[k]);
    for (int k = 0; k < MEM_LAT + 2; k++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset two cycles into an IF read wait: the read must vanish
    applyStimulus(1, 32'h40, 0, 0, 0, 0);
    checkOutput("rstwait if_ack", if_ack, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'h1;
    #1;
    checkOutput("rstwait dm_ack", dm_ack, 0);
    checkOutput("rstwait mem_write", mem_write, 0);
    checkOutput("rstwait mem_address", mem_address, 0);
    checkOutput("rstwait if_rvalid", if_rvalid, 0);
    checkOutput("rstwait if_rdata", if_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dm_req = 0; dm_we = 0;
    for (int k = 0; k < MEM_LAT + 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rstwait stale if_rvalid", if_rvalid, 0);
    end
    applyStimulus(1, 32'h100, 0, 0, 0, 0);
    checkOutput("post-reset if_ack", if_ack, 1);
    checkOutput("post-reset mem_read", mem_read, 1);
    for (int k = 0; k < MEM_LAT; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post-reset early if_rvalid", if_rvalid, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post-reset if_rvalid", if_rvalid, 1);
    checkOutput("post-reset if_rdata", if_rdata, 32'h12345678);

    // Randomized phase against the transaction-level model
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    m_busy = 0; m_losses = 0; m_cyc = 0; m_rv_at = -1; m_rv_dm = 0; m_rv_data = 0;
    m_if_rdata = 0; m_dm_rdata = 0;
    if_pend = 0; dm_pend = 0; r_dm_we = 0;
    r_if_addr = 0; r_dm_addr = 0; r_dm_wdata = 0;

    for (int n = 0; n < 400; n++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; r_if_addr = rand_addr();
      end
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend = 1; r_dm_addr = rand_addr();
        r_dm_we = 1'($urandom_range(0, 1)); r_dm_wdata = $urandom;
      end
      applyStimulus(if_pend, r_if_addr, dm_pend, r_dm_we, r_dm_addr, r_dm_wdata);

      exp_if_rv = (m_rv_at == m_cyc) && !m_rv_dm;
      exp_dm_rv = (m_rv_at == m_cyc) && m_rv_dm;
      if (exp_if_rv) m_if_rdata = m_rv_data;
      if (exp_dm_rv) m_dm_rdata = m_rv_data;
      g_if = 0; g_dm = 0; bad = 0; do_read = 0; do_write = 0; g_addr = 0;
      if (m_busy == 0) begin
        g_if = if_pend && (!dm_pend || m_losses >= STARVE_MAX);
        g_dm = dm_pend && !g_if;
        g_addr = g_if ? r_if_addr : r_dm_addr;
        bad = (g_if || g_dm) && (g_addr[1:0] != 2'b00);
        do_write = g_dm && r_dm_we && !bad;
        do_read = (g_if || g_dm) && !bad && !do_write;
        if (!if_pend || g_if) m_losses = 0;
        else if (g_dm) m_losses = (m_losses < STARVE_MAX) ? m_losses + 1 : STARVE_MAX;
      end else begin
        m_busy--;
      end

      checkOutput("rnd if_ack", if_ack, g_if);
      checkOutput("rnd dm_ack", dm_ack, g_dm);
      checkOutput("rnd if_err", if_err, g_if && bad);
      checkOutput("rnd dm_err", dm_err, g_dm && bad);
      checkOutput("rnd mem_read", mem_read, do_read);
      checkOutput("rnd mem_write", mem_write, do_write);
      checkOutput("rnd if_rvalid", if_rvalid, exp_if_rv);
      checkOutput("rnd dm_rvalid", dm_rvalid, exp_dm_rv);
      checkOutput("rnd if_rdata", if_rdata, m_if_rdata);
      checkOutput("rnd dm_rdata", dm_rdata, m_dm_rdata);
      if (do_read || do_write) checkOutput("rnd mem_address", mem_address, g_addr);
      if (do_write) checkOutput("rnd mem_data_in", mem_data_in, r_dm_wdata);

      if (do_read) begin
        m_busy = MEM_LAT;
        m_rv_at = m_cyc + MEM_LAT + 1;
        m_rv_dm = g_dm;
        m_rv_data = ref_mem[g_addr[11:2]];
      end
      if (do_write) ref_mem[g_addr[11:2]] = r_dm_wdata;
      if (g_if) if_pend = 0;
      if (g_dm) dm_pend = 0;
      m_cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
